// File: rtl/ram_dump_tx.sv
// Streams N consecutive RAM words out as little-endian bytes through a UART
// trmt/tx_data/tx_done handshake. The top byte of each word is sign-extended.
module ram_dump_tx #(
  parameter int DATA_W         = 18,
  parameter int ADDR_W         = 10,
  parameter int BYTES_PER_WORD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int EXT_W = BYTES_PER_WORD * 8;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, LOAD, SEND, WAIT_TX, FINISH
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     remain_q;
  logic [DATA_W-1:0]   word_q;
  logic [IDX_W-1:0]    byte_idx_q;
  logic                ram_rd_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                trmt_q;
  logic [7:0]          tx_data_q;
  logic                busy_q;
  logic                done_q;

  // Signed cast widens the word to whole bytes, replicating the MSB.
  logic [EXT_W-1:0]    word_ext;
  logic [7:0]          byte_sel;
  assign word_ext = EXT_W'($signed(word_q));
  assign byte_sel = word_ext[{byte_idx_q, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      trmt_q     <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= word_cnt;
            if (word_cnt == '0) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              busy_q     <= 1'b1;
              ram_rd_q   <= 1'b1;
              ram_addr_q <= base_addr;
              state_q    <= READ;
            end
          end
        end
        READ: begin
          ram_rd_q <= 1'b0;
          state_q  <= LATCH;
        end
        LATCH: begin
          word_q     <= ram_q;
          byte_idx_q <= '0;
          state_q    <= LOAD;
        end
        LOAD: begin
          tx_data_q <= byte_sel;
          trmt_q    <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          trmt_q  <= 1'b0;
          state_q <= WAIT_TX;
        end
        WAIT_TX: begin
          // tx_data stays registered here, so the UART sees a stable byte.
          if (tx_done) begin
            if (byte_idx_q != LAST_IDX) begin
              byte_idx_q <= byte_idx_q + IDX_W'(1);
              state_q    <= LOAD;
            end else if (remain_q == (ADDR_W+1)'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              remain_q   <= remain_q - (ADDR_W+1)'(1);
              addr_q     <= addr_q + ADDR_W'(1);
              ram_rd_q   <= 1'b1;
              ram_addr_q <= addr_q + ADDR_W'(1);
              state_q    <= READ;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_rd   = ram_rd_q;
  assign ram_addr = ram_addr_q;
  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed + randomized bench for ram_dump_tx with a RAM model, a UART
// responder and a byte-level reference computed from signed word values.
module tb_ram_dump_tx;
  localparam int DW  = 18;
  localparam int AW  = 10;
  localparam int BPW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ram_dump_tx #(.DATA_W(DW), .ADDR_W(AW), .BYTES_PER_WORD(BPW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  bit uart_en;
  bit rand_dly;
  initial begin : uart
    int d;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt && uart_en) begin
        d = rand_dly ? int'($urandom_range(20, 1)) : 10;
        repeat (d) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  int byte_q[$];
  int gap_q[$];
  int rd_q[$];
  int cyc, trmt_cnt, done_cnt, txd_cnt, last_done_cyc, txd_at_done, rd_outside;
  initial begin : monitor
    cyc = 0; trmt_cnt = 0; done_cnt = 0; txd_cnt = 0;
    last_done_cyc = 0; txd_at_done = 0; rd_outside = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (trmt) begin
        byte_q.push_back(int'(tx_data));
        gap_q.push_back(cyc - last_done_cyc);
        trmt_cnt++;
      end
      if (done) begin
        done_cnt++;
        txd_at_done = txd_cnt;
      end
      if (tx_done) begin
        txd_cnt++;
        last_done_cyc = cyc;
      end
      if (ram_rd) begin
        rd_q.push_back(int'(ram_addr));
        if (!busy) rd_outside++;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: interpret the word as a signed DW-bit value, then slice bytes.
  function automatic int exp_byte(input int word, input int k);
    int v;
    v = word;
    if (v >= (1 << (DW-1))) v = v - (1 << DW);
    return (v >>> (8*k)) & 255;
  endfunction

  function automatic int get_b(input int idx);
    return (idx < byte_q.size()) ? byte_q[idx] : -1;
  endfunction

  function automatic int get_rd(input int idx);
    return (idx < rd_q.size()) ? rd_q[idx] : -1;
  endfunction

  task automatic pulse_start(input int base, input int cnt);
    @(negedge clk);
    base_addr = AW'(base);
    word_cnt  = (AW+1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int busy_gaps);
    int n;
    busy_gaps = 0;
    n = 0;
    while (n < limit && !done) begin
      if (!busy) busy_gaps++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, ~done}, 0);
    @(negedge clk);
  endtask

  task automatic wait_trmts(input int t0, input int k);
    int n;
    n = 0;
    while (n < 2000 && (trmt_cnt - t0) < k) begin
      @(negedge clk);
      n++;
    end
    chk("wait_trmt_timeout", trmt_cnt - t0, k);
  endtask

  initial begin : main
    int b0, r0, t0, d0, x0, gaps, bad, v, e;
    int words2 [2];
    int wwrap [2];
    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    uart_en = 1'b1; rand_dly = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (50) @(negedge clk);
    chk("idle_trmt_cnt", trmt_cnt, 0);

    // Two-word dump
    words2[0] = 18'h2ABCD; words2[1] = 18'h1FFFF;
    mem[5] = DW'(words2[0]); mem[6] = DW'(words2[1]);
    b0 = byte_q.size(); r0 = rd_q.size(); t0 = trmt_cnt; d0 = done_cnt;
    x0 = txd_cnt;
    pulse_start(5, 2);
    wait_done("two", 2000, gaps);
    chk("two_busy_gaps", gaps, 0);
    chk("two_trmt_cnt", trmt_cnt - t0, 6);
    chk("two_done_cnt", done_cnt - d0, 1);
    chk("two_done_after_6th", txd_at_done - x0, 6);
    chk("two_rd0", get_rd(r0), 5);
    chk("two_rd1", get_rd(r0 + 1), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("two_byte%0d", i), get_b(b0 + i), exp_byte(words2[i/3], i%3));
    for (int i = 1; i < 6; i++)
      chk($sformatf("two_gap%0d", i), gap_q[b0 + i], (i == 3) ? 4 : 2);

    // Zero count
    r0 = rd_q.size(); t0 = trmt_cnt;
    pulse_start(9, 0);
    chk("zero_done_next", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_width", done, 0);
    repeat (10) @(negedge clk);
    chk("zero_rd_cnt", rd_q.size() - r0, 0);
    chk("zero_trmt_cnt", trmt_cnt - t0, 0);

    // Address wrap
    wwrap[0] = 18'h00001; wwrap[1] = 18'h20000;
    mem[1023] = DW'(wwrap[0]); mem[0] = DW'(wwrap[1]);
    b0 = byte_q.size(); r0 = rd_q.size(); t0 = trmt_cnt;
    pulse_start(1023, 2);
    wait_done("wrap", 2000, gaps);
    chk("wrap_rd0", get_rd(r0), 1023);
    chk("wrap_rd1", get_rd(r0 + 1), 0);
    chk("wrap_trmt_cnt", trmt_cnt - t0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("wrap_byte%0d", i), get_b(b0 + i), exp_byte(wwrap[i/3], i%3));

    // Start while busy
    b0 = byte_q.size(); r0 = rd_q.size(); t0 = trmt_cnt; d0 = done_cnt;
    pulse_start(5, 2);
    wait_trmts(t0, 3);
    pulse_start(0, 5);
    wait_done("busy", 2000, gaps);
    repeat (40) @(negedge clk);
    chk("busy_trmt_cnt", trmt_cnt - t0, 6);
    chk("busy_done_cnt", done_cnt - d0, 1);
    chk("busy_rd_cnt", rd_q.size() - r0, 2);
    for (int i = 0; i < 6; i++)
      chk($sformatf("busy_byte%0d", i), get_b(b0 + i), exp_byte(words2[i/3], i%3));

    // Full layer with random UART latency
    for (int i = 0; i < 676; i++) mem[i] = DW'((i * 37) % (1 << DW));
    rand_dly = 1'b1;
    b0 = byte_q.size(); r0 = rd_q.size(); t0 = trmt_cnt; d0 = done_cnt;
    pulse_start(0, 676);
    wait_done("full", 60000, gaps);
    chk("full_busy_gaps", gaps, 0);
    chk("full_trmt_cnt", trmt_cnt - t0, 2028);
    chk("full_done_cnt", done_cnt - d0, 1);
    bad = 0;
    for (int w = 0; w < 676; w++) begin
      v = get_b(b0 + 3*w) | (get_b(b0 + 3*w + 1) << 8) | (get_b(b0 + 3*w + 2) << 16);
      if (v >= (1 << 23)) v = v - (1 << 24);
      e = (w * 37) % (1 << DW);
      if (e >= (1 << (DW-1))) e = e - (1 << DW);
      if (v != e || get_b(b0 + 3*w + 2) < 0) bad++;
      if (get_rd(r0 + w) != w) bad++;
    end
    chk("full_word_errors", bad, 0);
    rand_dly = 1'b0;

    // Reset in the middle of WAIT_TX
    uart_en = 1'b0;
    t0 = trmt_cnt; d0 = done_cnt;
    pulse_start(5, 2);
    wait_trmts(t0, 1);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_trmt", trmt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ram_rd", ram_rd, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    uart_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_trmt_cnt", trmt_cnt - t0, 1);
    chk("rd_outside_busy", rd_outside, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
